mem_wb_stage: RTL and testbench

- MEM/WB pipeline boundary and write-back stage of the 5-stage MIPS32 core.
- Registers the data-memory read result, the ALU result, the link address and the destination control coming out of the memory stage.
- Selects the register-file write-back value and drives the register-file write port.
- Counts retired instructions for the debug unit and implements a halt handshake: the pipeline drains after a HALT instruction retires.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mux.sv | 25 ++
 rtl/sat_counter.sv | 26 ++
 rtl/mem_wb_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Purpose: shared write-back source codes and MEM/WB stage state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  // Write-back source select codes; 2'b11 is treated as ALU by the stage.
  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_LINK = 2'b10;

  // Halt handshake states of the MEM/WB stage.
  typedef enum logic [1:0] {
    RUN    = 2'd0,  // capturing MEM-stage results
    DRAIN  = 2'd1,  // HALT sits in WB, retires on next enabled edge
    HALTED = 2'd2   // frozen until reset
  } wb_state_t;

endpackage : mips_pkg

// File: rtl/mux.sv
// Purpose: generic N-channel combinational selector; out-of-range select gives 0.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data - packed channel array (channel 0 in the low bits),
//        i_sel  - channel index, o_data - selected channel.
module mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0][WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]               i_sel,
  output logic [WIDTH-1:0]               o_data
);

  always_comb begin
    o_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_sel == c[SEL_W-1:0]) begin
        o_data = i_data[c];
      end
    end
  end

endmodule : mux

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: count updates on the rising edge after i_en.
// Backpressure: none; i_en=0 holds the count.
// Ports: i_clk, i_clear_n (async active-low clear), i_en, o_count.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clear_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter

// File: rtl/mem_wb_stage.sv
// Purpose: MEM/WB pipeline register, write-back select, retire counter and halt drain.
// Latency: one cycle from MEM-stage inputs to WB outputs.
// Backpressure: i_enable=0 freezes everything; after HALT retires the stage stays frozen until reset.
// Ports: i_clk/i_reset (async active-low), i_enable, i_flush, MEM-stage slot inputs
//        (i_valid, i_halt, i_reg_wr, i_wb_src, i_rd_addr, i_mem_rd, i_alu_result, i_pc_link);
//        register-file write port (o_reg_wr, o_rd_addr, o_wb_data), o_valid, o_retired, o_halted.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int IO_BUS_SIZE   = 32,
  parameter int REG_ADDR_SIZE = 5,
  parameter int CNT_SIZE      = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic                     i_halt,
  input  logic                     i_reg_wr,
  input  logic [1:0]               i_wb_src,
  input  logic [REG_ADDR_SIZE-1:0] i_rd_addr,
  input  logic [IO_BUS_SIZE-1:0]   i_mem_rd,
  input  logic [IO_BUS_SIZE-1:0]   i_alu_result,
  input  logic [IO_BUS_SIZE-1:0]   i_pc_link,
  output logic                     o_reg_wr,
  output logic [REG_ADDR_SIZE-1:0] o_rd_addr,
  output logic [IO_BUS_SIZE-1:0]   o_wb_data,
  output logic                     o_valid,
  output logic [CNT_SIZE-1:0]      o_retired,
  output logic                     o_halted
);

  wb_state_t                r_state, w_state_next;
  logic                     w_capture;
  logic                     w_count_en;

  logic                     r_valid;
  logic                     r_reg_wr;
  logic [1:0]               r_wb_src;
  logic [REG_ADDR_SIZE-1:0] r_rd_addr;
  logic [IO_BUS_SIZE-1:0]   r_mem_rd;
  logic [IO_BUS_SIZE-1:0]   r_alu_result;
  logic [IO_BUS_SIZE-1:0]   r_pc_link;

  logic [1:0]               w_sel;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Only RUN captures; once a HALT is in WB the slot contents are held so the
  // HALT itself is what retires on the DRAIN edge.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    if (i_enable) begin
      case (r_state)
        RUN: begin
          w_capture = 1'b1;
          if (!i_flush && i_valid && i_halt) begin
            w_state_next = DRAIN;
          end
        end
        DRAIN:   w_state_next = HALTED;
        default: w_state_next = r_state;
      endcase
    end
  end

  // The instruction currently in WB leaves on this edge.
  assign w_count_en = i_enable && (r_state != HALTED) && r_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid      <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_wb_src     <= '0;
      r_rd_addr    <= '0;
      r_mem_rd     <= '0;
      r_alu_result <= '0;
      r_pc_link    <= '0;
    end else if (w_capture) begin
      if (i_flush) begin
        // Bubble: only the control bits clear, data fields keep their value.
        r_valid  <= 1'b0;
        r_reg_wr <= 1'b0;
      end else begin
        r_valid      <= i_valid;
        r_reg_wr     <= i_reg_wr & i_valid;
        r_wb_src     <= i_wb_src;
        r_rd_addr    <= i_rd_addr;
        r_mem_rd     <= i_mem_rd;
        r_alu_result <= i_alu_result;
        r_pc_link    <= i_pc_link;
      end
    end
  end

  // Code 2'b11 aliases ALU so the 3-channel selector never sees it.
  assign w_sel = (r_wb_src == 2'b11) ? WB_SRC_ALU : r_wb_src;

  mux #(
    .WIDTH    (IO_BUS_SIZE),
    .CHANNELS (3),
    .SEL_W    (2)
  ) u_wb_mux (
    .i_data ({r_pc_link, r_mem_rd, r_alu_result}),
    .i_sel  (w_sel),
    .o_data (o_wb_data)
  );

  sat_counter #(
    .WIDTH (CNT_SIZE)
  ) u_retired (
    .i_clk     (i_clk),
    .i_clear_n (i_reset),
    .i_en      (w_count_en),
    .o_count   (o_retired)
  );

  assign o_rd_addr = r_rd_addr;
  assign o_halted  = (r_state == HALTED);
  assign o_valid   = r_valid && (r_state != HALTED);
  assign o_reg_wr  = r_reg_wr && r_valid && (r_rd_addr != '0) && (r_state != HALTED);

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk;
  logic        i_reset, i_enable, i_flush, i_valid, i_halt, i_reg_wr;
  logic [1:0]  i_wb_src;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_mem_rd, i_alu_result, i_pc_link;

  logic        o_reg_wr, o_valid, o_halted;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_wb_data, o_retired;

  logic        s_reg_wr, s_valid, s_halted;
  logic [4:0]  s_rd_addr;
  logic [31:0] s_wb_data;
  logic [3:0]  s_retired;

  int compared = 0;
  int mismatched = 0;

  mem_wb_stage dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .i_halt(i_halt), .i_reg_wr(i_reg_wr), .i_wb_src(i_wb_src),
    .i_rd_addr(i_rd_addr), .i_mem_rd(i_mem_rd), .i_alu_result(i_alu_result),
    .i_pc_link(i_pc_link), .o_reg_wr(o_reg_wr), .o_rd_addr(o_rd_addr),
    .o_wb_data(o_wb_data), .o_valid(o_valid), .o_retired(o_retired), .o_halted(o_halted)
  );

  // Narrow-counter copy sharing the same stimulus, to exercise saturation.
  mem_wb_stage #(.CNT_SIZE(4)) dut_sat (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .i_halt(i_halt), .i_reg_wr(i_reg_wr), .i_wb_src(i_wb_src),
    .i_rd_addr(i_rd_addr), .i_mem_rd(i_mem_rd), .i_alu_result(i_alu_result),
    .i_pc_link(i_pc_link), .o_reg_wr(s_reg_wr), .o_rd_addr(s_rd_addr),
    .o_wb_data(s_wb_data), .o_valid(s_valid), .o_retired(s_retired), .o_halted(s_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction sitting in WB plus retirement bookkeeping.
  logic        m_valid, m_reg_wr, m_halt_in_wb, m_halted;
  logic [1:0]  m_src;
  logic [4:0]  m_rd;
  logic [31:0] m_mem, m_alu, m_link;
  longint      m_count;

  task automatic model_reset();
    m_valid = 0; m_reg_wr = 0; m_halt_in_wb = 0; m_halted = 0;
    m_src = 0; m_rd = 0; m_mem = 0; m_alu = 0; m_link = 0; m_count = 0;
  endtask

  task automatic model_edge();
    if (!i_enable || m_halted) return;
    if (m_valid) m_count++;
    if (m_halt_in_wb) begin
      m_halted = 1;
      return;
    end
    if (i_flush) begin
      m_valid = 0; m_reg_wr = 0;
    end else begin
      m_valid = i_valid; m_reg_wr = i_reg_wr && i_valid;
      m_src = i_wb_src; m_rd = i_rd_addr;
      m_mem = i_mem_rd; m_alu = i_alu_result; m_link = i_pc_link;
      if (i_valid && i_halt) m_halt_in_wb = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_data;
    longint      c32, c4;
    exp_data = (m_src == 2'b01) ? m_mem : (m_src == 2'b10) ? m_link : m_alu;
    c32 = (m_count > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count;
    c4  = (m_count > 15) ? 15 : m_count;
    chk("wb_data", o_wb_data, exp_data);
    chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, m_rd});
    chk("reg_wr",  {31'd0, o_reg_wr}, {31'd0, m_reg_wr && m_valid && (m_rd != 0) && !m_halted});
    chk("valid",   {31'd0, o_valid}, {31'd0, m_valid && !m_halted});
    chk("halted",  {31'd0, o_halted}, {31'd0, m_halted});
    chk("retired", o_retired, c32[31:0]);
    chk("retired_sat", {28'd0, s_retired}, c4[31:0]);
    chk("halted_sat",  {31'd0, s_halted}, {31'd0, m_halted});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_inputs(input int halt_pct);
    i_enable     = ($urandom_range(0, 7) != 0);
    i_flush      = ($urandom_range(0, 7) == 0);
    i_valid      = ($urandom_range(0, 3) != 0);
    i_halt       = (halt_pct > 0) && ($urandom_range(0, 99) < halt_pct);
    i_reg_wr     = 1'($urandom);
    i_wb_src     = 2'($urandom);
    i_rd_addr    = 5'($urandom);
    i_mem_rd     = $urandom;
    i_alu_result = $urandom;
    i_pc_link    = $urandom;
  endtask

  task automatic drive(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [31:0] link);
    i_enable = 1; i_flush = 0; i_valid = 1; i_halt = 0; i_reg_wr = 1;
    i_wb_src = src; i_rd_addr = rd; i_mem_rd = mem; i_alu_result = alu; i_pc_link = link;
  endtask

  longint saved;

  initial begin
    i_reset = 0; i_enable = 0; i_flush = 0; i_valid = 0; i_halt = 0; i_reg_wr = 0;
    i_wb_src = 0; i_rd_addr = 0; i_mem_rd = 0; i_alu_result = 0; i_pc_link = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    i_reset = 1;

    // Memory-load write-back.
    drive(2'b01, 5'd8, 32'hFFFF_FF80, 32'h0000_1000, 32'h0);
    cycle();
    chk("load_data", o_wb_data, 32'hFFFF_FF80);
    chk("load_rd", {27'd0, o_rd_addr}, 32'd8);
    chk("load_wr", {31'd0, o_reg_wr}, 32'd1);
    chk("load_not_yet_retired", o_retired, 32'd0);
    // Link, alias-11 and r0 suppression.
    drive(2'b10, 5'd31, 32'h0, 32'h0, 32'h0000_0048);
    cycle();
    chk("load_retired", o_retired, 32'd1);
    chk("link_data", o_wb_data, 32'h0000_0048);
    drive(2'b11, 5'd3, 32'hDEAD_BEEF, 32'h0000_1234, 32'hCAFE_0000);
    cycle();
    chk("src11_data", o_wb_data, 32'h0000_1234);
    drive(2'b00, 5'd0, 32'h0, 32'h5555_AAAA, 32'h0);
    cycle();
    chk("r0_suppressed", {31'd0, o_reg_wr}, 32'd0);

    // Flush with valid inputs, then enable low with random inputs.
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 5'd9, $urandom, $urandom, $urandom);
      i_flush = 1;
      i_halt = (k == 1);
      cycle();
      chk("flush_valid", {31'd0, o_valid}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      rand_inputs(50);
      i_enable = 0;
      cycle();
    end

    // Random run without HALT, then asynchronous reset mid-cycle.
    for (int k = 0; k < 40; k++) begin
      rand_inputs(0);
      cycle();
    end
    #2;
    i_reset = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    i_reset = 1;
    drive(2'b00, 5'd4, 32'h0, 32'h0000_0777, 32'h0);
    cycle();
    chk("resume_data", o_wb_data, 32'h0000_0777);

    // Saturation of the 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      drive(2'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      cycle();
    end
    chk("sat_at_15", {28'd0, s_retired}, 32'd15);

    // HALT handshake.
    drive(2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    i_halt = 1; i_reg_wr = 0;
    cycle();
    chk("halt_edge_n", {31'd0, o_halted}, 32'd0);
    saved = m_count;
    rand_inputs(50); i_enable = 1; i_valid = 1;
    cycle();
    chk("halt_edge_n1", {31'd0, o_halted}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      rand_inputs(0); i_enable = 1; i_valid = 1; i_flush = 0;
      cycle();
      chk("halt_frozen", o_retired, saved[31:0] + 32'd1);
    end

    // Reset out of HALTED, then random traffic including HALTs.
    i_reset = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    i_reset = 1;
    for (int k = 0; k < 300; k++) begin
      rand_inputs(4);
      if (m_halted && $urandom_range(0, 5) == 0) begin
        i_reset = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        i_reset = 1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_wb_stage
